// File: rtl/bulk_read_arbiter_pkg.sv
// rtl/bulk_read_arbiter_pkg.sv - shared types and helpers for the bulk read arbiter
// Provides the arbiter state encoding and the requester-index width helper.
package bulk_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_RESP = 2'd2
  } arb_state_t;

  localparam int N_REQ_DEFAULT = 2;
  localparam int ID_W = (N_REQ_DEFAULT > 1) ? $clog2(N_REQ_DEFAULT) : 1;

  // Index width for an arbitrary requester count; never collapses to zero bits.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bulk_read_arbiter_rr_pick.sv
// rtl/bulk_read_arbiter_rr_pick.sv - combinational round-robin priority picker
// Ports:
//   req       in  N   request vector
//   ptr       in  W   index with highest priority this round
//   idx       out W   winning index (first set bit at ptr, ptr+1, ... mod N)
//   any_valid out 1   at least one request bit set
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any_valid
);

  always_comb begin
    int cand;
    cand      = 0;
    idx       = '0;
    any_valid = |req;
    // Walk from the farthest offset back to ptr so the nearest set bit wins last.
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (req[cand[W-1:0]]) idx = cand[W-1:0];
    end
  end

endmodule

// File: rtl/bulk_read_arbiter.sv
// rtl/bulk_read_arbiter.sv - round-robin arbiter sharing one bulk-line port
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   r_req_* (valid/ready/write/addr/wdata/wstrb)  per-requester line requests
//   r_resp_valid, r_resp_rdata     one-hot read completion, broadcast line data
//   d_req_* (valid/ready/write/addr/wdata/wstrb)  downstream request port
//   d_resp_valid, d_resp_rdata     downstream read completion
//   timeout_err, timeout_id        sticky watchdog flag and owner at timeout
module bulk_read_arbiter
  import bulk_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int LINE_SIZE = 16,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     r_req_valid,
  output logic [N_REQ-1:0]                     r_req_ready,
  input  logic [N_REQ-1:0]                     r_req_write,
  input  logic [N_REQ*ADDR_W-1:0]              r_req_addr,
  input  logic [N_REQ*LINE_SIZE*DATA_W-1:0]    r_req_wdata,
  input  logic [N_REQ*LINE_SIZE*DATA_W/8-1:0]  r_req_wstrb,
  output logic [N_REQ-1:0]                     r_resp_valid,
  output logic [LINE_SIZE*DATA_W-1:0]          r_resp_rdata,
  output logic                                 d_req_valid,
  input  logic                                 d_req_ready,
  output logic                                 d_req_write,
  output logic [ADDR_W-1:0]                    d_req_addr,
  output logic [LINE_SIZE*DATA_W-1:0]          d_req_wdata,
  output logic [LINE_SIZE*DATA_W/8-1:0]        d_req_wstrb,
  input  logic                                 d_resp_valid,
  input  logic [LINE_SIZE*DATA_W-1:0]          d_resp_rdata,
  output logic                                 timeout_err,
  output logic [$clog2(N_REQ)-1:0]             timeout_id
);

  localparam int SEL_W  = id_width(N_REQ);
  localparam int LINE_W = LINE_SIZE * DATA_W;
  localparam int STRB_W = LINE_W / 8;
  localparam int WD_W   = $clog2(TIMEOUT + 1);

  arb_state_t        state_q, state_d;
  logic [SEL_W-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              err_q, err_d;
  logic [SEL_W-1:0]  tid_q, tid_d;

  logic [SEL_W-1:0]  pick_idx;
  logic              pick_any;
  logic              sel_valid;
  logic              sel_write;
  logic [SEL_W-1:0]  grant_next;

  rr_pick #(
    .N (N_REQ),
    .W (SEL_W)
  ) u_pick (
    .req       (r_req_valid),
    .ptr       (rr_ptr_q),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  assign sel_valid    = r_req_valid[grant_q];
  assign sel_write    = r_req_write[grant_q];
  assign grant_next   = (grant_q == SEL_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign r_resp_rdata = d_resp_rdata;
  assign timeout_err  = err_q;
  assign timeout_id   = tid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
      tid_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
      tid_q    <= tid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    wd_cnt_d     = wd_cnt_q;
    err_d        = err_q;
    tid_d        = tid_q;
    r_req_ready  = '0;
    r_resp_valid = '0;
    d_req_valid  = 1'b0;
    d_req_write  = 1'b0;
    d_req_addr   = '0;
    d_req_wdata  = '0;
    d_req_wstrb  = '0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        d_req_valid          = sel_valid;
        d_req_write          = sel_write;
        d_req_addr           = r_req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
        d_req_wdata          = r_req_wdata[int'(grant_q)*LINE_W +: LINE_W];
        d_req_wstrb          = r_req_wstrb[int'(grant_q)*STRB_W +: STRB_W];
        r_req_ready[grant_q] = d_req_ready;
        if (!sel_valid) begin
          // Owner withdrew: rearbitrate without advancing the pointer.
          state_d = ARB_IDLE;
        end else if (d_req_ready) begin
          rr_ptr_d = grant_next;
          if (sel_write) begin
            state_d = ARB_IDLE;
          end else begin
            state_d  = ARB_WAIT_RESP;
            wd_cnt_d = '0;
          end
        end
      end

      ARB_WAIT_RESP: begin
        if (d_resp_valid) begin
          r_resp_valid[grant_q] = 1'b1;
          state_d               = ARB_IDLE;
        end else begin
          if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
            err_d = 1'b1;
            tid_d = grant_q;
          end
          if (wd_cnt_q != WD_W'(TIMEOUT)) wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bulk_read_arbiter.sv
// tb/tb_bulk_read_arbiter.sv - scoreboard bench for bulk_read_arbiter
module tb_bulk_read_arbiter;

  localparam int N     = 3;
  localparam int LS    = 4;
  localparam int DW    = 64;
  localparam int AW    = 64;
  localparam int TO    = 16;
  localparam int LW    = LS * DW;
  localparam int SW    = LW / 8;
  localparam int NTX   = 80;
  localparam int LIMIT = 20000;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    r_req_valid, r_req_ready, r_req_write, r_resp_valid;
  logic [N*AW-1:0] r_req_addr;
  logic [N*LW-1:0] r_req_wdata;
  logic [N*SW-1:0] r_req_wstrb;
  logic [LW-1:0]   r_resp_rdata;
  logic            d_req_valid, d_req_ready, d_req_write;
  logic [AW-1:0]   d_req_addr;
  logic [LW-1:0]   d_req_wdata;
  logic [SW-1:0]   d_req_wstrb;
  logic            d_resp_valid;
  logic [LW-1:0]   d_resp_rdata;
  logic            timeout_err;
  logic [1:0]      timeout_id;

  bulk_read_arbiter #(
    .N_REQ(N), .LINE_SIZE(LS), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_write(r_req_write),
    .r_req_addr(r_req_addr), .r_req_wdata(r_req_wdata), .r_req_wstrb(r_req_wstrb),
    .r_resp_valid(r_resp_valid), .r_resp_rdata(r_resp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_write(d_req_write),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .timeout_err(timeout_err), .timeout_id(timeout_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } dreq_t;

  typedef struct {
    logic [N-1:0]  onehot;
    logic [LW-1:0] rdata;
  } resp_t;

  dreq_t exp_dreq[$];
  resp_t exp_resp[$];
  int    n_cmp   = 0;
  int    n_bad   = 0;
  logic  exp_err = 1'b0;
  int    exp_tid = 0;
  logic  rd_out  = 1'b0;
  int    rr_m    = 0;
  int    owner   = 0;

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic load(input int i, input logic wr);
    logic [LW-1:0] w;
    logic [AW-1:0] a;
    for (int k = 0; k < LW / 32; k++) w[k*32 +: 32] = $urandom;
    a = {8'(i), 24'($urandom), $urandom};
    r_req_write[i]            = wr;
    r_req_addr[i*AW +: AW]    = a;
    r_req_wdata[i*LW +: LW]   = w;
    r_req_wstrb[i*SW +: SW]   = $urandom;
    r_req_valid[i]            = 1'b1;
  endtask

  // Reference decision: first pending requester at or after the rotation pointer.
  task automatic arbitrate();
    dreq_t e;
    int    w;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && r_req_valid[(rr_m + k) % N]) w = (rr_m + k) % N;
    e.write = r_req_write[w];
    e.addr  = r_req_addr[w*AW +: AW];
    e.wdata = r_req_wdata[w*LW +: LW];
    e.wstrb = r_req_wstrb[w*SW +: SW];
    exp_dreq.push_back(e);
    rr_m  = (w + 1) % N;
    owner = w;
  endtask

  always @(negedge clk) begin
    dreq_t e;
    resp_t r;
    if (!rst) begin
      rd_out = 1'b0;
    end else begin
      if (d_req_valid && d_req_ready) begin
        chk("dreq_overlap", LW'(rd_out), LW'(0));
        chk("ready_onehot", LW'($countones(r_req_ready)), LW'(1));
        if (exp_dreq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL dreq_unexpected: got addr %0h expected none", d_req_addr);
        end else begin
          e = exp_dreq.pop_front();
          chk("dreq_write", LW'(d_req_write), LW'(e.write));
          chk("dreq_addr", LW'(d_req_addr), LW'(e.addr));
          chk("dreq_wdata", d_req_wdata, e.wdata);
          chk("dreq_wstrb", LW'(d_req_wstrb), LW'(e.wstrb));
          rd_out = !e.write;
        end
      end else begin
        chk("ready_idle", LW'(r_req_ready), LW'(0));
      end
      if (r_resp_valid != '0) begin
        if (exp_resp.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL resp_unexpected: got %0b expected none", r_resp_valid);
        end else begin
          r = exp_resp.pop_front();
          chk("resp_onehot", LW'(r_resp_valid), LW'(r.onehot));
          chk("resp_rdata", r_resp_rdata, r.rdata);
          chk("resp_err", LW'(timeout_err), LW'(exp_err));
          if (exp_err) chk("resp_err_id", LW'(timeout_id), LW'(exp_tid));
        end
        rd_out = 1'b0;
      end
    end
  end

  initial begin
    logic [N-1:0] req_hs;
    logic         d_hs, d_hs_wr, resp_on, rd_wait, boundary, hs;
    int           wcyc, rd_delay, lat, done, nrd, stall;
    resp_t        rp;

    r_req_valid = '1;
    r_req_write = '0;
    r_req_addr  = '0;
    r_req_wdata = '0;
    r_req_wstrb = '0;
    d_req_ready = 1'b1;
    d_resp_valid = 1'b1;
    d_resp_rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_d_req_valid", LW'(d_req_valid), LW'(0));
    chk("rst_r_req_ready", LW'(r_req_ready), LW'(0));
    chk("rst_r_resp_valid", LW'(r_resp_valid), LW'(0));
    chk("rst_d_req_write", LW'(d_req_write), LW'(0));
    chk("rst_d_req_addr", LW'(d_req_addr), LW'(0));
    chk("rst_d_req_wdata", d_req_wdata, LW'(0));
    chk("rst_d_req_wstrb", LW'(d_req_wstrb), LW'(0));
    chk("rst_timeout_err", LW'(timeout_err), LW'(0));
    chk("rst_timeout_id", LW'(timeout_id), LW'(0));
    r_req_valid  = '0;
    d_resp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // First transaction: directed write from requester 0.
    load(0, 1'b1);
    r_req_wdata[LW-1:0] = LW'(64'hDEAD_BEEF);
    r_req_wstrb[SW-1:0] = '1;
    arbitrate();
    lat = 2; done = 0; nrd = 0; stall = 0; wcyc = 0; rd_delay = 0;
    resp_on = 1'b0; rd_wait = 1'b0;

    for (int cyc = 0; cyc < LIMIT && done < NTX; cyc++) begin
      @(negedge clk);
      req_hs  = r_req_valid & r_req_ready;
      d_hs    = d_req_valid & d_req_ready;
      d_hs_wr = d_req_write;
      if (lat == 2) begin
        chk("arb_idle_cycle", LW'(d_req_valid), LW'(0));
        lat = 1;
      end else if (lat == 1) begin
        chk("issue_cycle_valid", LW'(d_req_valid), LW'(1));
        lat = 0;
      end
      if (rd_wait && wcyc == TO - 1) chk("wd_before_limit", LW'(timeout_err), LW'(exp_err));
      if (rd_wait && wcyc == TO) begin
        chk("wd_at_limit", LW'(timeout_err), LW'(1));
        chk("wd_at_limit_id", LW'(timeout_id), LW'(owner));
      end

      @(posedge clk);
      #1;
      r_req_valid = r_req_valid & ~req_hs;
      boundary    = 1'b0;
      if (d_hs) begin
        if (d_hs_wr) begin
          boundary = 1'b1;
          done++;
        end else begin
          rd_wait  = 1'b1;
          wcyc     = 0;
          nrd++;
          rd_delay = (nrd % 6 == 0) ? $urandom_range(TO + 8, TO) : $urandom_range(6, 0);
        end
      end else if (rd_wait) begin
        if (resp_on) begin
          d_resp_valid = 1'b0;
          resp_on      = 1'b0;
          rd_wait      = 1'b0;
          boundary     = 1'b1;
          done++;
        end else begin
          wcyc++;
          if (wcyc == TO) begin
            exp_err = 1'b1;
            exp_tid = owner;
          end
        end
      end
      if (rd_wait && !resp_on && wcyc == rd_delay) begin
        for (int k = 0; k < LW / 32; k++) rp.rdata[k*32 +: 32] = $urandom;
        rp.onehot    = N'(1) << owner;
        d_resp_rdata = rp.rdata;
        d_resp_valid = 1'b1;
        exp_resp.push_back(rp);
        resp_on = 1'b1;
      end
      if ((rd_wait || boundary) && done < NTX)
        for (int i = 0; i < N; i++)
          if (!r_req_valid[i] && !(rd_wait && i == owner) && ($urandom % 4 == 0))
            load(i, 1'($urandom % 2));
      if (boundary && done < NTX) begin
        if (r_req_valid == '0) load(int'($urandom % N), 1'($urandom % 2));
        arbitrate();
        lat = 2;
      end
      if (stall > 0) begin
        d_req_ready = 1'b0;
        stall--;
      end else if ($urandom % 12 == 0) begin
        stall       = $urandom_range(12, 6);
        d_req_ready = 1'b0;
      end else begin
        d_req_ready = ($urandom % 4 != 0);
      end
    end
    chk("tx_completed", LW'(done), LW'(NTX));

    // Reset while a read from requester 1 is outstanding, then a stale response.
    r_req_valid  = '0;
    d_req_ready  = 1'b0;
    d_resp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_dreq.delete();
    load(1, 1'b0);
    arbitrate();
    d_req_ready = 1'b1;
    hs = 1'b0;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk);
      hs = r_req_valid[1] & r_req_ready[1];
    end
    chk("rst_test_handshake", LW'(hs), LW'(1));
    @(posedge clk);
    #1;
    r_req_valid = '0;
    d_req_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_d_req_valid", LW'(d_req_valid), LW'(0));
    chk("async_r_req_ready", LW'(r_req_ready), LW'(0));
    chk("async_r_resp_valid", LW'(r_resp_valid), LW'(0));
    chk("async_timeout_err", LW'(timeout_err), LW'(0));
    chk("async_timeout_id", LW'(timeout_id), LW'(0));
    exp_err = 1'b0;
    exp_dreq.delete();
    exp_resp.delete();
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    d_resp_rdata = {8{$urandom}};
    d_resp_valid = 1'b1;
    @(negedge clk);
    chk("stale_resp_dropped", LW'(r_resp_valid), LW'(0));
    @(posedge clk);
    #1;
    d_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_after_reset", LW'(timeout_err), LW'(0));
    chk("idle_after_stale", LW'(d_req_valid), LW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
